// File: rtl/yin_pkg.sv
// Shared types and width helpers for the YIN pitch-detection path.
// Holds the sweep FSM state encoding and accumulator width functions.
package yin_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    EMIT,
    DONE
  } state_t;

  function automatic int acc_width(int dw, int wb);
    return 2 * dw + wb;
  endfunction

  function automatic int csum_width(int dw, int wb, int tb);
    return acc_width(dw, wb) + tb;
  endfunction

endpackage

// File: rtl/yin_sq_diff.sv
// Two-stage squared difference |a-b|^2; stage 1 magnitude, stage 2 square.
// Ports: clk, reset (async low), in_valid/a/b in, out_valid/sq out.
module yin_sq_diff #(
  parameter int DATA_WIDTH  = 8,
  parameter bit SIGNED_DATA = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [DATA_WIDTH-1:0]     a,
  input  logic [DATA_WIDTH-1:0]     b,
  output logic                      out_valid,
  output logic [2*DATA_WIDTH-1:0]   sq
);

  logic                  neg;
  logic [DATA_WIDTH-1:0] mag;
  logic [DATA_WIDTH-1:0] mag_q;
  logic                  v1;
  logic [2*DATA_WIDTH-1:0] m;

  // Sign of the (DATA_WIDTH+1)-bit difference; the magnitude always
  // fits DATA_WIDTH bits, so a modulo subtraction of the larger
  // minus the smaller is exact.
  always_comb begin
    if (SIGNED_DATA) neg = $signed(a) < $signed(b);
    else             neg = a < b;
    mag = neg ? (b - a) : (a - b);
  end

  assign m = {{DATA_WIDTH{1'b0}}, mag_q};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1        <= 1'b0;
      mag_q     <= '0;
      out_valid <= 1'b0;
      sq        <= '0;
    end else begin
      v1        <= in_valid;
      mag_q     <= mag;
      out_valid <= v1;
      sq        <= m * m;
    end
  end

endmodule

// File: rtl/yin_diff_sweep.sv
// YIN difference-function sweep: d(tau) over a RAM window, tau_min..tau_max.
// Ports: start/base/tau range in, RAM read port, res_* stream, best_* arg-min.
module yin_diff_sweep
  import yin_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int WINDOW_SIZE_BITS = 8,
  parameter int TAU_BITS         = 6,
  parameter int ADDR_WIDTH       = 16,
  parameter bit SIGNED_DATA      = 1'b0,
  localparam int ACC_WIDTH  = acc_width(DATA_WIDTH, WINDOW_SIZE_BITS),
  localparam int CSUM_WIDTH =
    csum_width(DATA_WIDTH, WINDOW_SIZE_BITS, TAU_BITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [TAU_BITS-1:0]   tau_min,
  input  logic [TAU_BITS-1:0]   tau_max,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [TAU_BITS-1:0]   res_tau,
  output logic [ACC_WIDTH-1:0]  res_diff,
  output logic [CSUM_WIDTH-1:0] res_cumsum,
  output logic [TAU_BITS-1:0]   best_tau,
  output logic [ACC_WIDTH-1:0]  best_diff
);

  localparam int CW = WINDOW_SIZE_BITS + 1;
  localparam logic [CW-1:0] CNT_LAST = '1;

  state_t state, nxt;

  logic [CW-1:0]           cnt;
  logic                    dcnt;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [TAU_BITS-1:0]     tau_q;
  logic [TAU_BITS-1:0]     tmax_q;
  logic                    rd_d;
  logic                    ph_d;
  logic [DATA_WIDTH-1:0]   a_q;
  logic                    sq_v;
  logic [2*DATA_WIDTH-1:0] sq;
  logic [ACC_WIDTH-1:0]    acc;
  logic [ACC_WIDTH-1:0]    acc_sum;
  logic [CSUM_WIDTH-1:0]   csum;
  logic                    go;
  logic                    hs;
  logic                    enter_read;

  assign go         = (state == IDLE) && start;
  assign hs         = (state == EMIT) && res_ready;
  assign enter_read = (nxt == READ) && (state != READ);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = (tau_min > tau_max) ? DONE : READ;
      READ:  if (cnt == CNT_LAST) nxt = DRAIN;
      DRAIN: if (dcnt) nxt = EMIT;
      EMIT:  if (res_ready) nxt = (tau_q == tmax_q) ? DONE : READ;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Even cycles fetch x[base+j], odd cycles x[base+j+tau].
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    res_valid = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    unique case (state)
      READ: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = base_q + ADDR_WIDTH'(cnt[CW-1:1])
                  + (cnt[0] ? ADDR_WIDTH'(tau_q) : '0);
      end
      DRAIN: busy = 1'b1;
      EMIT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  yin_sq_diff #(
    .DATA_WIDTH  (DATA_WIDTH),
    .SIGNED_DATA (SIGNED_DATA)
  ) u_sq (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_d && ph_d),
    .a         (a_q),
    .b         (mem_data),
    .out_valid (sq_v),
    .sq        (sq)
  );

  // The last square lands in the first EMIT cycle, so the result
  // folds it in combinationally and stays stable afterwards.
  always_comb begin
    acc_sum = acc;
    if (sq_v) acc_sum = acc + ACC_WIDTH'(sq);
  end

  assign res_tau    = tau_q;
  assign res_diff   = acc_sum;
  assign res_cumsum = csum + CSUM_WIDTH'(acc_sum);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      dcnt      <= 1'b0;
      base_q    <= '0;
      tau_q     <= '0;
      tmax_q    <= '0;
      rd_d      <= 1'b0;
      ph_d      <= 1'b0;
      a_q       <= '0;
      acc       <= '0;
      csum      <= '0;
      best_tau  <= '0;
      best_diff <= '1;
    end else begin
      rd_d <= mem_rd_en;
      ph_d <= cnt[0];
      if (rd_d && !ph_d) a_q <= mem_data;
      if (state == READ) cnt <= cnt + CW'(1);
      if (state == DRAIN) dcnt <= ~dcnt;
      acc <= enter_read ? '0 : acc_sum;
      if (go) begin
        base_q    <= base_addr;
        tau_q     <= tau_min;
        tmax_q    <= tau_max;
        cnt       <= '0;
        dcnt      <= 1'b0;
        csum      <= '0;
        best_tau  <= '0;
        best_diff <= '1;
      end
      if (hs) begin
        csum <= csum + CSUM_WIDTH'(acc_sum);
        if (acc_sum < best_diff) begin
          best_tau  <= tau_q;
          best_diff <= acc_sum;
        end
        if (tau_q != tmax_q) tau_q <= tau_q + TAU_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_yin_diff_sweep.sv
// Scoreboard bench for yin_diff_sweep with a 16-sample window.
// Expected d/cumsum come from a software model of the RAM contents.
module tb_yin_diff_sweep;

  localparam int NW = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [5:0]  tau_min = '0;
  logic [5:0]  tau_max = '0;
  logic        busy, done, mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [5:0]  res_tau;
  logic [19:0] res_diff;
  logic [25:0] res_cumsum;
  logic [5:0]  best_tau;
  logic [19:0] best_diff;

  yin_diff_sweep #(
    .DATA_WIDTH       (8),
    .WINDOW_SIZE_BITS (4),
    .TAU_BITS         (6),
    .ADDR_WIDTH       (16),
    .SIGNED_DATA      (1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .tau_min    (tau_min),
    .tau_max    (tau_max),
    .busy       (busy),
    .done       (done),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_tau    (res_tau),
    .res_diff   (res_diff),
    .res_cumsum (res_cumsum),
    .best_tau   (best_tau),
    .best_diff  (best_diff)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     tau;
    longint d;
    longint cs;
  } exp_t;

  logic [7:0]  ram [0:65535];
  exp_t        exp_q[$];
  exp_t        e;
  int          vrise[$];
  int          rdst[$];
  logic [15:0] alog[$];
  longint      dtau[int];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  logic        done_busy = 1'b0;
  int          hs_cnt = 0;
  int          last_hs = 0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;

  always @(posedge clk) cyc++;

  // RAM answers one cycle after a read; otherwise junk on the bus.
  always @(posedge clk)
    mem_data <= mem_rd_en ? ram[mem_addr] : 8'($urandom);

  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      hs_cnt++;
      last_hs = cyc;
      dtau[int'(res_tau)] = longint'(res_diff);
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL result_extra: got tau=%0d d=%0d, required none",
                 res_tau, res_diff);
      end else begin
        e = exp_q.pop_front();
        if (res_tau !== 6'(e.tau) || res_diff !== 20'(e.d) ||
            res_cumsum !== 26'(e.cs)) begin
          n_bad++;
          $display("FAIL result: got tau=%0d d=%0d cs=%0d, required tau=%0d d=%0d cs=%0d",
                   res_tau, res_diff, res_cumsum, e.tau, e.d, e.cs);
        end
      end
    end
    if (res_valid && !pv) vrise.push_back(cyc);
    if (mem_rd_en && !pr) rdst.push_back(cyc);
    if (mem_rd_en && alog.size() < 64) alog.push_back(mem_addr);
    if (done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = busy;
    end
    pv = res_valid;
    pr = mem_rd_en;
  end

  function automatic longint dval(int base, int tau);
    longint s = 0;
    for (int j = 0; j < NW; j++) begin
      int a = int'(ram[(base + j) & 16'hFFFF]);
      int b = int'(ram[(base + j + tau) & 16'hFFFF]);
      s += longint'((a - b) * (a - b));
    end
    return s;
  endfunction

  task automatic push_exp(int base, int tmin, int tmax);
    longint cs = 0;
    for (int t = tmin; t <= tmax; t++) begin
      exp_t x;
      x.tau = t;
      x.d   = dval(base, t);
      cs   += x.d;
      x.cs  = cs;
      exp_q.push_back(x);
    end
  endtask

  task automatic run(int base, int tmin, int tmax, output int t_total);
    vrise.delete();
    rdst.delete();
    alog.delete();
    dtau.delete();
    done_cnt = 0;
    hs_cnt   = 0;
    @(negedge clk);
    base_addr = 16'(base);
    tau_min   = 6'(tmin);
    tau_max   = 6'(tmax);
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3000 && done_cnt == 0; i++) @(negedge clk);
    if (done_cnt == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sweep_timeout: got no done, required done within 3000 cycles");
    end
    t_total = done_cyc - start_cyc;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, mem_rd_en, res_valid} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_ctrl: got %b, required 0000",
               {busy, done, mem_rd_en, res_valid});
    end
    n_cmp++;
    if (mem_addr !== 16'h0) begin
      n_bad++;
      $display("FAIL rst_addr: got %h, required 0000", mem_addr);
    end
    n_cmp++;
    if (res_tau !== 6'd0 || res_diff !== 20'd0 || res_cumsum !== 26'd0) begin
      n_bad++;
      $display("FAIL rst_res: got %0d/%0d/%0d, required 0/0/0",
               res_tau, res_diff, res_cumsum);
    end
    n_cmp++;
    if (best_tau !== 6'd0 || best_diff !== 20'hFFFFF) begin
      n_bad++;
      $display("FAIL rst_best: got %0d/%h, required 0/fffff",
               best_tau, best_diff);
    end
    reset = 1'b1;
  endtask

  task automatic test_constant();
    int tt;
    for (int i = 0; i < 65536; i++) ram[i] = 8'h55;
    push_exp(0, 1, 5);
    fork
      begin
        repeat (20) @(negedge clk);
        tau_min = 6'd0;
        tau_max = 6'd0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join_none
    run(0, 1, 5, tt);
    n_cmp++;
    if (hs_cnt !== 5 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL const_count: got %0d results, required 5", hs_cnt);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL const_done: got %0d pulses busy=%b, required 1 busy=0",
               done_cnt, done_busy);
    end
    n_cmp++;
    if (best_tau !== 6'd1 || best_diff !== 20'd0) begin
      n_bad++;
      $display("FAIL const_best: got %0d/%0d, required 1/0",
               best_tau, best_diff);
    end
  endtask

  task automatic test_ramp();
    int tt;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
    push_exp(0, 0, 3);
    run(0, 0, 3, tt);
    n_cmp++;
    if (hs_cnt !== 4 || best_tau !== 6'd0 || best_diff !== 20'd0) begin
      n_bad++;
      $display("FAIL ramp_best: got n=%0d best=%0d/%0d, required n=4 best=0/0",
               hs_cnt, best_tau, best_diff);
    end
    n_cmp++;
    if (rdst.size() !== 4 || vrise.size() !== 4) begin
      n_bad++;
      $display("FAIL ramp_edges: got %0d reads %0d valids, required 4/4",
               rdst.size(), vrise.size());
    end else begin
      n_cmp++;
      if (rdst[0] !== start_cyc + 1) begin
        n_bad++;
        $display("FAIL ramp_first_read: got cycle %0d, required %0d",
                 rdst[0], start_cyc + 1);
      end
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (vrise[k] - rdst[k] !== 2 * NW + 2) begin
          n_bad++;
          $display("FAIL ramp_latency: got %0d, required %0d",
                   vrise[k] - rdst[k], 2 * NW + 2);
        end
      end
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (rdst[k + 1] - rdst[k] !== 2 * NW + 3) begin
          n_bad++;
          $display("FAIL ramp_period: got %0d, required %0d",
                   rdst[k + 1] - rdst[k], 2 * NW + 3);
        end
      end
    end
    n_cmp++;
    if (done_cyc !== last_hs + 1 || tt !== 1 + 4 * (2 * NW + 3)) begin
      n_bad++;
      $display("FAIL ramp_done: got done@%0d total %0d, required %0d/%0d",
               done_cyc, tt, last_hs + 1, 1 + 4 * (2 * NW + 3));
    end
  endtask

  task automatic test_square();
    int tt;
    for (int i = 0; i < 65536; i++) ram[i] = ((i >> 2) & 1) ? 8'd100 : 8'd0;
    push_exp(0, 1, 10);
    run(0, 1, 10, tt);
    n_cmp++;
    if (hs_cnt !== 10 || !dtau.exists(4) || !dtau.exists(8)) begin
      n_bad++;
      $display("FAIL sq_count: got %0d results, required 10", hs_cnt);
    end else begin
      n_cmp++;
      if (dtau[4] !== 64'd160000 || dtau[8] !== 64'd0) begin
        n_bad++;
        $display("FAIL sq_d: got d4=%0d d8=%0d, required 160000/0",
                 dtau[4], dtau[8]);
      end
    end
    n_cmp++;
    if (best_tau !== 6'd8 || best_diff !== 20'd0) begin
      n_bad++;
      $display("FAIL sq_best: got %0d/%0d, required 8/0",
               best_tau, best_diff);
    end
  endtask

  task automatic test_back_to_back();
    int t0, t1;
    int stall_bad = 0;
    logic hit = 1'b0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i * 7);
    push_exp(0, 1, 5);
    run(0, 1, 5, t0);
    push_exp(0, 1, 5);
    fork
      begin
        logic [5:0]  st;
        logic [19:0] sd;
        logic [25:0] sc;
        for (int i = 0; i < 3000 && !hit; i++) begin
          @(posedge clk);
          #1;
          if (res_valid && res_tau == 6'd3) hit = 1'b1;
        end
        if (hit) begin
          res_ready = 1'b0;
          st = res_tau;
          sd = res_diff;
          sc = res_cumsum;
          repeat (10) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_tau !== st || res_diff !== sd ||
                res_cumsum !== sc || mem_rd_en !== 1'b0) stall_bad++;
            @(posedge clk);
          end
          #1 res_ready = 1'b1;
        end
      end
    join_none
    run(0, 1, 5, t1);
    n_cmp++;
    if (hit !== 1'b1 || stall_bad !== 0) begin
      n_bad++;
      $display("FAIL stall_hold: got hit=%b unstable=%0d, required 1/0",
               hit, stall_bad);
    end
    n_cmp++;
    if (t1 - t0 !== 10) begin
      n_bad++;
      $display("FAIL stall_cycles: got +%0d, required +10", t1 - t0);
    end
    n_cmp++;
    if (hs_cnt !== 5 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL stall_count: got %0d results, required 5", hs_cnt);
    end
  endtask

  task automatic test_wrap();
    int tt;
    logic [15:0] ea [5];
    ea = '{16'hFFFE, 16'h0000, 16'hFFFF, 16'h0001, 16'h000F};
    for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);
    push_exp(16'hFFFE, 2, 2);
    run(16'hFFFE, 2, 2, tt);
    n_cmp++;
    if (alog.size() !== 2 * NW) begin
      n_bad++;
      $display("FAIL wrap_reads: got %0d, required %0d", alog.size(), 2 * NW);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (alog[k] !== ea[k]) begin
          n_bad++;
          $display("FAIL wrap_addr: got %h, required %h", alog[k], ea[k]);
        end
      end
      n_cmp++;
      if (alog[2 * NW - 1] !== ea[4]) begin
        n_bad++;
        $display("FAIL wrap_last: got %h, required %h",
                 alog[2 * NW - 1], ea[4]);
      end
    end
    n_cmp++;
    if (hs_cnt !== 1 || exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d results, required 1", hs_cnt);
    end
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 65536; i++) ram[i] = 8'(i);
    done_cnt = 0;
    hs_cnt   = 0;
    @(negedge clk);
    base_addr = 16'h0100;
    tau_min   = 6'd1;
    tau_max   = 6'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, mem_rd_en, res_valid} !== 4'b0 || mem_addr !== 16'h0) begin
      n_bad++;
      $display("FAIL abort_ctrl: got %b addr %h, required 0000 addr 0000",
               {busy, done, mem_rd_en, res_valid}, mem_addr);
    end
    n_cmp++;
    if (res_tau !== 6'd0 || res_diff !== 20'd0 || res_cumsum !== 26'd0 ||
        best_tau !== 6'd0 || best_diff !== 20'hFFFFF) begin
      n_bad++;
      $display("FAIL abort_res: got %0d/%0d/%0d/%0d/%h, required 0/0/0/0/fffff",
               res_tau, res_diff, res_cumsum, best_tau, best_diff);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (done_cnt !== 0 || hs_cnt !== 0) begin
      n_bad++;
      $display("FAIL abort_quiet: got done=%0d res=%0d, required 0/0",
               done_cnt, hs_cnt);
    end
    vrise.delete();
    tau_min   = 6'd7;
    tau_max   = 6'd3;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (vrise.size() !== 0 || done_cnt !== 1 || done_cyc !== start_cyc + 1 ||
        done_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_range: got valids=%0d done=%0d@%0d busy=%b, required 0/1@%0d/0",
               vrise.size(), done_cnt, done_cyc, done_busy, start_cyc + 1);
    end
    n_cmp++;
    if (best_tau !== 6'd0 || best_diff !== 20'hFFFFF || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL empty_best: got %0d/%h busy=%b, required 0/fffff/0",
               best_tau, best_diff, busy);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_ramp();
    test_square();
    test_back_to_back();
    test_wrap();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
